// File: rtl/pupil_pkg.sv
// Shared definitions for the pupil locator: FSM encoding, accumulator widths,
// default frame geometry and pixel width.
package pupil_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, CALC, DONE} state_t;

  localparam int PIX_W        = 10;
  localparam int CNT_W        = 19;
  localparam int SUM_W        = 28;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
endpackage

// File: rtl/pupil_locator_if.sv
// Pixel stream in / per-frame result out bundle for the pupil locator.
// The master is the pixel source, the slave is the locator.
interface pupil_locator_if
  import pupil_pkg::*;
#(
  parameter int COORD_W = 11
);
  logic               fval;
  logic               dval;
  logic [PIX_W-1:0]   data;
  logic [PIX_W-1:0]   thresh;
  logic [COORD_W-1:0] xMin, xMax, yMin, yMax, cx, cy;
  logic               found;
  logic               done;

  modport master (
    output fval, dval, data, thresh,
    input  xMin, xMax, yMin, yMax, cx, cy, found, done
  );

  modport slave (
    input  fval, dval, data, thresh,
    output xMin, xMax, yMin, yMax, cx, cy, found, done
  );
endinterface

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per cycle (SUM_W cycles after start).
// Only built when PUPIL_CENTROID_EN is defined.
`ifdef PUPIL_CENTROID_EN
module serial_divider
  import pupil_pkg::*;
#(
  parameter int OUT_W = 11
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [OUT_W-1:0] quot
);
  localparam int STEP_W = $clog2(SUM_W);

  logic              busy;
  logic [STEP_W-1:0] step;
  logic [CNT_W-1:0]  rem, dvs;
  logic [SUM_W-1:0]  q;
  logic [CNT_W:0]    shifted;
  logic              ge;

  assign shifted = {rem, q[SUM_W-1]};
  assign ge      = shifted >= {1'b0, dvs};
  // done flags the final step; the quotient is valid from the next cycle on
  assign done    = busy && (step == STEP_W'(SUM_W-1));
  assign quot    = q[OUT_W-1:0];

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      busy <= 1'b0;
      step <= '0;
      rem  <= '0;
      dvs  <= '0;
      q    <= '0;
    end else if (start) begin
      busy <= 1'b1;
      step <= '0;
      rem  <= '0;
      dvs  <= divisor;
      q    <= dividend;
    end else if (busy) begin
      rem  <= ge ? (shifted[CNT_W-1:0] - dvs) : shifted[CNT_W-1:0];
      q    <= {q[SUM_W-2:0], ge};
      step <= step + STEP_W'(1);
      if (done) busy <= 1'b0;
    end
  end
endmodule
`endif

// File: rtl/pupil_locator.sv
// Pupil locator: bounding box and centre of dark (below-threshold) pixels per frame.
// PUPIL_CENTROID_EN selects a true centroid via serial dividers; default is the bbox midpoint.
module pupil_locator
  import pupil_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int COORD_W  = 11
) (
  input logic            iCLK,
  input logic            iRST,
  pupil_locator_if.slave bus
);
  state_t             state, nxt;
  logic               fvalQ, fvalQQ, dvalQ;
  logic [PIX_W-1:0]   dataQ, thr;
  logic [COORD_W-1:0] x, y, xMin, xMax, yMin, yMax;
  logic               seen, rise, pixEn, dark, calcDone;
  logic [COORD_W-1:0] cxCalc, cyCalc;
  logic [COORD_W-1:0] resXMin, resXMax, resYMin, resYMax, resCx, resCy;
  logic               resFound, resDone;

  // Edge-detect history resets high so a frame already open at release is not a rise
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      fvalQ  <= 1'b1;
      fvalQQ <= 1'b1;
      dvalQ  <= 1'b0;
      dataQ  <= '0;
    end else begin
      fvalQ  <= bus.fval;
      fvalQQ <= fvalQ;
      dvalQ  <= bus.dval;
      dataQ  <= bus.data;
    end
  end

  assign rise  = fvalQ & ~fvalQQ;
  assign pixEn = (state == ACCUM) && fvalQ && dvalQ;
  assign dark  = dataQ < thr;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (rise)     nxt = ACCUM;
      ACCUM:   if (!fvalQ)   nxt = CALC;
      CALC:    if (calcDone) nxt = DONE;
      DONE:                  nxt = IDLE;
      default:               nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      x <= '0; y <= '0; seen <= 1'b0; thr <= '0;
      xMin <= '0; xMax <= '0; yMin <= '0; yMax <= '0;
    end else if (state == IDLE && rise) begin
      x <= '0; y <= '0; seen <= 1'b0; thr <= bus.thresh;
      xMin <= '0; xMax <= '0; yMin <= '0; yMax <= '0;
    end else if (pixEn) begin
      if (x == COORD_W'(H_ACTIVE-1)) begin
        x <= '0;
        if (y != COORD_W'(V_ACTIVE-1)) y <= y + COORD_W'(1);
      end else begin
        x <= x + COORD_W'(1);
      end
      // y never decreases, so the first dark row is the minimum
      if (dark) begin
        seen <= 1'b1;
        xMin <= (!seen || x < xMin) ? x : xMin;
        xMax <= (!seen || x > xMax) ? x : xMax;
        yMin <= seen ? yMin : y;
        yMax <= y;
      end
    end
  end

`ifdef PUPIL_CENTROID_EN
  logic [CNT_W-1:0]   count, divisor;
  logic [SUM_W-1:0]   sumX, sumY;
  logic               divStart, doneX, doneY;
  logic [COORD_W-1:0] qX, qY;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      count <= '0; sumX <= '0; sumY <= '0;
    end else if (state == IDLE && rise) begin
      count <= '0; sumX <= '0; sumY <= '0;
    end else if (pixEn && dark) begin
      count <= count + CNT_W'(1);
      sumX  <= sumX + SUM_W'(x);
      sumY  <= sumY + SUM_W'(y);
    end
  end

  // An empty frame divides 0 by 1 so CALC keeps its fixed length
  assign divisor  = (count == '0) ? CNT_W'(1) : count;
  assign divStart = (state == ACCUM) && !fvalQ;

  serial_divider #(.OUT_W(COORD_W)) uDivX (
    .iCLK(iCLK), .iRST(iRST), .start(divStart), .dividend(sumX),
    .divisor(divisor), .done(doneX), .quot(qX)
  );
  serial_divider #(.OUT_W(COORD_W)) uDivY (
    .iCLK(iCLK), .iRST(iRST), .start(divStart), .dividend(sumY),
    .divisor(divisor), .done(doneY), .quot(qY)
  );

  assign cxCalc   = qX;
  assign cyCalc   = qY;
  assign calcDone = doneX & doneY;
`else
  assign cxCalc   = COORD_W'(({1'b0, xMin} + {1'b0, xMax}) >> 1);
  assign cyCalc   = COORD_W'(({1'b0, yMin} + {1'b0, yMax}) >> 1);
  assign calcDone = 1'b1;
`endif

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      resXMin <= '0; resXMax <= '0; resYMin <= '0; resYMax <= '0;
      resCx <= '0; resCy <= '0; resFound <= 1'b0; resDone <= 1'b0;
    end else begin
      resDone <= (state == DONE);
      if (state == DONE) begin
        resFound <= seen;
        resXMin  <= seen ? xMin   : '0;
        resXMax  <= seen ? xMax   : '0;
        resYMin  <= seen ? yMin   : '0;
        resYMax  <= seen ? yMax   : '0;
        resCx    <= seen ? cxCalc : '0;
        resCy    <= seen ? cyCalc : '0;
      end
    end
  end

  assign bus.xMin  = resXMin;
  assign bus.xMax  = resXMax;
  assign bus.yMin  = resYMin;
  assign bus.yMax  = resYMax;
  assign bus.cx    = resCx;
  assign bus.cy    = resCy;
  assign bus.found = resFound;
  assign bus.done  = resDone;
endmodule

// File: tb/tb_pupil_locator.sv
// Directed bench for pupil_locator on an 8x4 frame with threshold 100.
// Honours PUPIL_CENTROID_EN for latency and re-rise spacing.
module tb_pupil_locator;
`ifdef PUPIL_CENTROID_EN
  localparam int LAT = 30;
  localparam int GAP = 5;
`else
  localparam int LAT = 3;
  localparam int GAP = 1;
`endif

  logic iCLK, iRST;
  int   total = 0, bad = 0, doneCnt = 0, d0;
  logic [9:0] pix [64];

  pupil_locator_if #(.COORD_W(11)) bus ();

  pupil_locator #(.H_ACTIVE(8), .V_ACTIVE(4), .COORD_W(11)) dut (
    .iCLK(iCLK), .iRST(iRST), .bus(bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) if (bus.done === 1'b1) doneCnt++;

  task automatic chk(input string tag, input logic [10:0] v, input logic [10:0] e);
    total++;
    assert (v === e) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, v, e);
    end
  endtask

  task automatic chkAll(input string tag, input int x0, x1, y0, y1, cx, cy, f);
    chk({tag, ".xMin"},  bus.xMin,  11'(x0));
    chk({tag, ".xMax"},  bus.xMax,  11'(x1));
    chk({tag, ".yMin"},  bus.yMin,  11'(y0));
    chk({tag, ".yMax"},  bus.yMax,  11'(y1));
    chk({tag, ".cx"},    bus.cx,    11'(cx));
    chk({tag, ".cy"},    bus.cy,    11'(cy));
    chk({tag, ".found"}, 11'(bus.found), 11'(f));
  endtask

  task automatic fill(input int a, input int b);
    for (int i = 0; i < 64; i++) pix[i] = 10'd200;
    if (a >= 0) pix[a] = 10'd50;
    if (b >= 0) pix[b] = 10'd50;
  endtask

  task automatic frame(input int nPix);
    bus.fval = 1'b1; bus.dval = 1'b0;
    @(negedge iCLK);
    for (int i = 0; i < nPix; i++) begin
      bus.dval = 1'b1; bus.data = pix[i];
      @(negedge iCLK);
    end
    bus.dval = 1'b0;
    @(negedge iCLK);
    bus.fval = 1'b0;
  endtask

  // fval has just been dropped; done must appear LAT edges later and last one cycle
  task automatic waitDone(input string tag);
    int k;
    k = 0;
    do begin @(negedge iCLK); k++; end while (bus.done !== 1'b1 && k < 200);
    chk({tag, ".latency"}, 11'(k), 11'(LAT + 1));
    @(negedge iCLK);
    chk({tag, ".pulse"}, 11'(bus.done), 11'd0);
  endtask

  initial begin
    iRST = 1'b0;
    bus.fval = 1'b0; bus.dval = 1'b0; bus.data = '0; bus.thresh = 10'd100;
    repeat (3) @(negedge iCLK);
    chkAll("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.done", 11'(bus.done), 11'd0);
    iRST = 1'b1;
    repeat (2) @(negedge iCLK);

    fill(2*8+3, -1);
    frame(32); waitDone("single");
    chkAll("single", 3, 3, 2, 2, 3, 2, 1);

    fill(1, 3*8+6);
    frame(32); waitDone("pair");
    chkAll("pair", 1, 6, 0, 3, 3, 1, 1);

    fill(-1, -1); pix[10] = 10'd100;
    frame(32); waitDone("none");
    chkAll("none", 0, 0, 0, 0, 0, 0, 0);

    // stray pixels outside a frame must not count
    bus.dval = 1'b1; bus.data = '0;
    repeat (3) @(negedge iCLK);
    bus.dval = 1'b0;
    fill(31, -1);
    frame(32); waitDone("corner");
    chkAll("corner", 7, 7, 3, 3, 7, 3, 1);

    // pixels past the last line stay on the saturated bottom row
    fill(33, -1);
    frame(40); waitDone("sat");
    chkAll("sat", 1, 1, 3, 3, 1, 3, 1);

    fill(5, 12);
    bus.fval = 1'b1; @(negedge iCLK);
    for (int i = 0; i < 10; i++) begin
      bus.dval = 1'b1; bus.data = pix[i]; @(negedge iCLK);
    end
    bus.dval = 1'b0; iRST = 1'b0;
    @(negedge iCLK);
    chkAll("inReset", 0, 0, 0, 0, 0, 0, 0);
    chk("inReset.done", 11'(bus.done), 11'd0);
    @(negedge iCLK);
    iRST = 1'b1;
    for (int i = 10; i < 20; i++) begin
      bus.dval = 1'b1; bus.data = pix[i]; @(negedge iCLK);
    end
    bus.dval = 1'b0; @(negedge iCLK);
    bus.fval = 1'b0;
    d0 = doneCnt;
    repeat (LAT + 5) @(negedge iCLK);
    chk("rstDrop.doneCnt", 11'(doneCnt - d0), 11'd0);
    chk("rstDrop.found", 11'(bus.found), 11'd0);
    fill(1*8+2, -1);
    frame(32); waitDone("afterRst");
    chkAll("afterRst", 2, 2, 1, 1, 2, 1, 1);

    // a frame opening while the previous one is still being finished is dropped
    d0 = doneCnt;
    fill(0, -1);
    frame(32);
    fill(31, -1);
    repeat (GAP) @(negedge iCLK);
    frame(32);
    repeat (LAT + 5) @(negedge iCLK);
    chk("drop.doneCnt", 11'(doneCnt - d0), 11'd1);
    chkAll("drop", 0, 0, 0, 0, 0, 0, 1);
    fill(2*8+5, -1);
    frame(32); waitDone("afterDrop");
    chkAll("afterDrop", 5, 5, 2, 2, 5, 2, 1);
    chk("doneTotal", 11'(doneCnt), 11'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
